// File: rtl/pc_sequencer_if.sv
// Control and result bundle between a fetch-control master and the PC sequencer.
// The master side drives redirect requests; the slave side returns the PC and status.
interface pc_sequencer_if #(
   parameter int unsigned WIDTH = 32
);
   logic             Stall;
   logic             Branch;
   logic             Jump;
   logic             Call;
   logic             Ret;
   logic             Halt;
   logic [WIDTH-1:0] Address;
   logic [WIDTH-1:0] PCResult;
   logic             Valid;
   logic             Halted;
   logic             RasOverflow;
   logic             RasUnderflow;

   modport master (
      output Stall, Branch, Jump, Call, Ret, Halt, Address,
      input  PCResult, Valid, Halted, RasOverflow, RasUnderflow
   );

   modport slave (
      input  Stall, Branch, Jump, Call, Ret, Halt, Address,
      output PCResult, Valid, Halted, RasOverflow, RasUnderflow
   );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: BOOT/RUN/HALTED control, prioritised redirects and
// a circular return-address stack that overwrites its oldest entry when full.
module pc_sequencer #(
   parameter int unsigned     WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter logic [WIDTH-1:0] INC          = WIDTH'(4),
   parameter int unsigned     RAS_DEPTH    = 4
) (
   input  logic           Clk,
   input  logic           Reset,
   pc_sequencer_if.slave  bus
);

   localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
   logic [PTR_W-1:0] ras_head;
   logic [CNT_W-1:0] ras_cnt;

   logic [WIDTH-1:0] pc_inc;
   logic [WIDTH-1:0] ras_top;
   logic             ras_empty;
   logic             ras_full;
   logic             do_push;

   // ras_head is the next write slot; when full it also points at the oldest entry
   assign pc_inc    = bus.PCResult + INC;
   assign ras_top   = ras_mem[ras_head - PTR_W'(1)];
   assign ras_empty = (ras_cnt == '0);
   assign ras_full  = (ras_cnt == CNT_W'(RAS_DEPTH));
   assign do_push   = (state == RUN) && !bus.Stall && !bus.Halt && !bus.Ret && bus.Call;

   // Entry storage carries no reset; only the count and pointer are cleared
   always_ff @(posedge Clk) begin
      if (do_push) begin
         ras_mem[ras_head] <= pc_inc;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state            <= BOOT;
         bus.PCResult     <= RESET_VECTOR;
         bus.Valid        <= 1'b0;
         bus.Halted       <= 1'b0;
         bus.RasOverflow  <= 1'b0;
         bus.RasUnderflow <= 1'b0;
         ras_head         <= '0;
         ras_cnt          <= '0;
      end else begin
         bus.RasOverflow  <= 1'b0;
         bus.RasUnderflow <= 1'b0;
         case (state)
            BOOT: begin
               state     <= RUN;
               bus.Valid <= 1'b1;
            end
            RUN: begin
               if (!bus.Stall) begin
                  if (bus.Halt) begin
                     state      <= HALTED;
                     bus.Valid  <= 1'b0;
                     bus.Halted <= 1'b1;
                  end else if (bus.Ret) begin
                     if (ras_empty) begin
                        bus.PCResult     <= pc_inc;
                        bus.RasUnderflow <= 1'b1;
                     end else begin
                        bus.PCResult <= ras_top;
                        ras_head     <= ras_head - PTR_W'(1);
                        ras_cnt      <= ras_cnt - CNT_W'(1);
                     end
                  end else if (bus.Call) begin
                     bus.PCResult <= bus.Address;
                     ras_head     <= ras_head + PTR_W'(1);
                     if (ras_full) begin
                        bus.RasOverflow <= 1'b1;
                     end else begin
                        ras_cnt <= ras_cnt + CNT_W'(1);
                     end
                  end else if (bus.Jump || bus.Branch) begin
                     bus.PCResult <= bus.Address;
                  end else begin
                     bus.PCResult <= pc_inc;
                  end
               end
            end
            HALTED: begin
               state <= HALTED;
            end
            default: begin
               state <= BOOT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a 32-bit and an 8-bit instance run the same control
// stream against a queue-based reference; directed points pin known PC values.
module tb_pc_sequencer;

   localparam int unsigned DEPTH = 4;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        stall, branch, jump, call, ret, halt;
   logic [31:0] addr;

   int checks = 0;
   int errors = 0;

   always #5 Clk = ~Clk;

   pc_sequencer_if #(.WIDTH(32)) bus32 ();
   pc_sequencer_if #(.WIDTH(8))  bus8 ();

   assign bus32.Stall   = stall;
   assign bus32.Branch  = branch;
   assign bus32.Jump    = jump;
   assign bus32.Call    = call;
   assign bus32.Ret     = ret;
   assign bus32.Halt    = halt;
   assign bus32.Address = addr;
   assign bus8.Stall    = stall;
   assign bus8.Branch   = branch;
   assign bus8.Jump     = jump;
   assign bus8.Call     = call;
   assign bus8.Ret      = ret;
   assign bus8.Halt     = halt;
   assign bus8.Address  = addr[7:0];

   pc_sequencer #(.WIDTH(32), .RESET_VECTOR(32'h0), .INC(32'h4), .RAS_DEPTH(DEPTH)) u_dut32 (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus32.slave)
   );

   pc_sequencer #(.WIDTH(8), .RESET_VECTOR(8'h0), .INC(8'h4), .RAS_DEPTH(DEPTH)) u_dut8 (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus8.slave)
   );

   // Reference: the 8-bit instance is the 32-bit result taken modulo 256
   logic [31:0] m_pc;
   logic [31:0] m_ras[$];
   bit          m_boot, m_halted, m_valid, m_ovf, m_unf;

   always @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         m_pc = 32'h0; m_boot = 1; m_halted = 0; m_valid = 0; m_ovf = 0; m_unf = 0;
         m_ras.delete();
      end else begin
         m_ovf = 0;
         m_unf = 0;
         if (m_boot) begin
            m_boot  = 0;
            m_valid = 1;
         end else if (m_halted || stall) begin
            m_pc = m_pc;
         end else if (halt) begin
            m_halted = 1;
            m_valid  = 0;
         end else if (ret) begin
            if (m_ras.size() == 0) begin
               m_pc  = m_pc + 32'd4;
               m_unf = 1;
            end else begin
               m_pc = m_ras.pop_back();
            end
         end else if (call) begin
            m_ras.push_back(m_pc + 32'd4);
            if (m_ras.size() > DEPTH) begin
               void'(m_ras.pop_front());
               m_ovf = 1;
            end
            m_pc = addr;
         end else if (jump || branch) begin
            m_pc = addr;
         end else begin
            m_pc = m_pc + 32'd4;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge Clk) begin
      chk("pc32",   bus32.PCResult,              m_pc);
      chk("pc8",    {24'h0, bus8.PCResult},       {24'h0, m_pc[7:0]});
      chk("valid32", {31'h0, bus32.Valid},        {31'h0, m_valid});
      chk("valid8",  {31'h0, bus8.Valid},         {31'h0, m_valid});
      chk("halt32",  {31'h0, bus32.Halted},       {31'h0, m_halted});
      chk("halt8",   {31'h0, bus8.Halted},        {31'h0, m_halted});
      chk("ovf32",   {31'h0, bus32.RasOverflow},  {31'h0, m_ovf});
      chk("ovf8",    {31'h0, bus8.RasOverflow},   {31'h0, m_ovf});
      chk("unf32",   {31'h0, bus32.RasUnderflow}, {31'h0, m_unf});
      chk("unf8",    {31'h0, bus8.RasUnderflow},  {31'h0, m_unf});
   end

   // Apply one cycle of controls at a falling edge; returns at the next falling edge
   task automatic cyc(input logic s, input logic h, input logic r, input logic c,
                      input logic j, input logic b, input logic [31:0] a);
      stall = s; halt = h; ret = r; call = c; jump = j; branch = b; addr = a;
      @(negedge Clk);
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0, 32'h0);
   endtask

   initial begin
      Reset = 1'b1;
      stall = 0; halt = 0; ret = 0; call = 0; jump = 0; branch = 0; addr = 32'h0;
      repeat (2) @(posedge Clk);
      #1 Reset = 1'b0;
      @(negedge Clk);
      chk("boot_pc", bus32.PCResult, 32'h0);
      chk("boot_valid", {31'h0, bus32.Valid}, 32'h0);

      idle();                      chk("run_pc0", bus32.PCResult, 32'h0);
      chk("run_valid", {31'h0, bus32.Valid}, 32'h1);
      idle();                      chk("seq4", bus32.PCResult, 32'h4);
      idle();                      chk("seq8", bus32.PCResult, 32'h8);

      cyc(0, 0, 0, 0, 1, 0, 32'h100); chk("jump", bus32.PCResult, 32'h100);
      idle();                         chk("jump_inc", bus32.PCResult, 32'h104);
      cyc(1, 0, 0, 0, 1, 0, 32'h900); chk("stall1", bus32.PCResult, 32'h104);
      cyc(1, 0, 0, 1, 0, 0, 32'h900); chk("stall2", bus32.PCResult, 32'h104);
      idle();                         chk("post_stall", bus32.PCResult, 32'h108);

      cyc(0, 0, 0, 0, 0, 1, 32'h10);  chk("branch", bus32.PCResult, 32'h10);
      cyc(0, 0, 0, 1, 0, 0, 32'h200); chk("call", bus32.PCResult, 32'h200);
      idle();                         chk("call_inc", bus32.PCResult, 32'h204);
      cyc(0, 0, 1, 0, 0, 0, 32'h0);   chk("ret", bus32.PCResult, 32'h14);

      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0, 0, 32'h300 + 32'(i) * 32'h100);
      chk("ovf_pc", bus32.PCResult, 32'h700);
      chk("ovf_pulse", {31'h0, bus32.RasOverflow}, 32'h1);
      cyc(0, 0, 1, 0, 0, 0, 32'h0);   chk("ret1", bus32.PCResult, 32'h604);
      chk("ovf_clear", {31'h0, bus32.RasOverflow}, 32'h0);
      cyc(0, 0, 1, 0, 0, 0, 32'h0);   chk("ret2", bus32.PCResult, 32'h504);
      cyc(0, 0, 1, 0, 0, 0, 32'h0);   chk("ret3", bus32.PCResult, 32'h404);
      cyc(0, 0, 1, 0, 0, 0, 32'h0);   chk("ret4", bus32.PCResult, 32'h304);
      cyc(0, 0, 1, 0, 0, 0, 32'h0);   chk("ret5_pc", bus32.PCResult, 32'h308);
      chk("unf_pulse", {31'h0, bus32.RasUnderflow}, 32'h1);
      idle();                         chk("unf_clear", {31'h0, bus32.RasUnderflow}, 32'h0);

      cyc(0, 0, 0, 0, 1, 0, 32'hFC);  chk("pre_wrap8", {24'h0, bus8.PCResult}, 32'hFC);
      idle();                         chk("wrap8", {24'h0, bus8.PCResult}, 32'h0);
      chk("nowrap32", bus32.PCResult, 32'h100);
      cyc(0, 0, 0, 1, 0, 0, 32'h40);  chk("call8", {24'h0, bus8.PCResult}, 32'h40);
      cyc(0, 0, 1, 1, 0, 0, 32'h80);  chk("retcall8", {24'h0, bus8.PCResult}, 32'h04);
      chk("retcall32", bus32.PCResult, 32'h104);
      cyc(0, 0, 1, 0, 0, 0, 32'h0);   chk("empty_after", {24'h0, bus8.PCResult}, 32'h08);
      chk("unf8_after", {31'h0, bus8.RasUnderflow}, 32'h1);

      cyc(0, 0, 0, 0, 1, 0, 32'h20);  chk("to20", bus32.PCResult, 32'h20);
      cyc(0, 1, 1, 0, 1, 0, 32'h300); chk("halt_pc", bus32.PCResult, 32'h20);
      chk("halted", {31'h0, bus32.Halted}, 32'h1);
      chk("halt_valid", {31'h0, bus32.Valid}, 32'h0);
      cyc(0, 0, 0, 0, 1, 0, 32'h300); chk("halt_jump", bus32.PCResult, 32'h20);
      cyc(0, 0, 0, 1, 0, 0, 32'h400); chk("halt_call", bus32.PCResult, 32'h20);
      cyc(0, 0, 1, 0, 0, 0, 32'h0);   chk("halt_ret", bus32.PCResult, 32'h20);

      #2 Reset = 1'b1;
      #1;
      chk("async_pc", bus32.PCResult, 32'h0);
      chk("async_halted", {31'h0, bus32.Halted}, 32'h0);
      chk("async_valid", {31'h0, bus32.Valid}, 32'h0);
      jump = 1; addr = 32'h500;
      @(posedge Clk);
      #1 Reset = 1'b0;
      @(negedge Clk);
      chk("boot2_valid", {31'h0, bus32.Valid}, 32'h0);
      cyc(0, 0, 0, 0, 1, 0, 32'h500); chk("boot_ignores", bus32.PCResult, 32'h0);
      idle();                         chk("boot2_seq", bus32.PCResult, 32'h4);
      idle();                         chk("boot2_seq2", bus32.PCResult, 32'h8);

      stall = 1;
      #2 Reset = 1'b1;
      #1;
      chk("stall_reset_pc", bus32.PCResult, 32'h0);
      @(posedge Clk);
      #1 Reset = 1'b0; stall = 0;
      @(negedge Clk);
      idle();                         chk("final_pc", bus32.PCResult, 32'h0);
      idle();                         chk("final_inc", bus32.PCResult, 32'h4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
